// File: rtl/frame_mem_scheduler.sv
// -----------------------------------------------------------------------------
// frame_mem_scheduler
//
// Arbitrates a 128-bit frame write stream and a frame read-request stream onto
// a single MIG-style memory command port. Each side keeps its own frame word
// pointer. A write wins a simultaneous request unless MAX_WR_BURST writes have
// been granted back-to-back since the last read grant. Reads are throttled by
// the number of read commands still waiting for their data.
//
// Optional feature: define ARB_STATS_EN to count the write and read commands
// that memory accepts. Without it, wr_count_out/rd_count_out are tied to 0.
//
// Ports
//   clk_in, rst_in            clock, synchronous active-low reset
//   wr_valid_in/ready_out     write stream handshake (ready = grant cycle)
//   wr_data_in, wr_tuser_in   write word, first-word-of-frame flag
//   rd_req_valid_in/ready_out read request handshake (ready = grant cycle)
//   rd_newframe_in            restart the read at frame word 0
//   rd_data_valid_out/data    read return, registered copy of memory return
//   app_*                     memory command / write-data / read-data ports
//   wr_count_out/rd_count_out accepted command counters (ARB_STATS_EN)
// -----------------------------------------------------------------------------
module frame_mem_scheduler #(
    parameter int FRAME_WORDS        = 115200,
    parameter int BASE_ADDR          = 0,
    parameter int ADDR_STEP          = 8,
    parameter int MAX_WR_BURST       = 8,
    parameter int MAX_RD_OUTSTANDING = 4
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         wr_valid_in,
    output logic         wr_ready_out,
    input  logic [127:0] wr_data_in,
    input  logic         wr_tuser_in,
    input  logic         rd_req_valid_in,
    output logic         rd_req_ready_out,
    input  logic         rd_newframe_in,
    output logic         rd_data_valid_out,
    output logic [127:0] rd_data_out,
    output logic [26:0]  app_addr_out,
    output logic [2:0]   app_cmd_out,
    output logic         app_en_out,
    input  logic         app_rdy_in,
    output logic [127:0] app_wdf_data_out,
    output logic         app_wdf_wren_out,
    output logic         app_wdf_end_out,
    input  logic         app_wdf_rdy_in,
    input  logic [127:0] app_rd_data_in,
    input  logic         app_rd_data_valid_in,
    output logic [31:0]  wr_count_out,
    output logic [31:0]  rd_count_out
);

    localparam int PW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int OW = $clog2(MAX_RD_OUTSTANDING + 1);
    localparam int BW = $clog2(MAX_WR_BURST + 1);
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

    state_t         r_state;
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [BW-1:0]  r_burst;
    logic [OW-1:0]  r_outst;
    logic           r_app_en;
    logic [2:0]     r_app_cmd;
    logic [26:0]    r_app_addr;
    logic [127:0]   r_wdf_data;
    logic           r_wdf_wren;
    logic           r_rd_vld;
    logic [127:0]   r_rd_data;

    logic           w_idle;
    logic           w_rd_ok;
    logic           w_burst_full;
    logic           w_wr_grant;
    logic           w_rd_grant;
    logic [PW-1:0]  w_wr_off;
    logic [PW-1:0]  w_rd_off;
    logic [PW-1:0]  w_wr_nxt;
    logic [PW-1:0]  w_rd_nxt;
    logic           w_cmd_acc;
    logic           w_rd_acc;
    logic           w_ret;
    logic           w_en_hold;
    logic           w_wren_hold;

    // Address arithmetic is done modulo 2^27, which equals truncating the
    // full-width result.
    function automatic logic [26:0] f_addr(input logic [PW-1:0] off);
        return 27'(BASE_ADDR) + 27'(off) * 27'(ADDR_STEP);
    endfunction

    // Grants are gated by rst_in so nothing handshakes while reset is held.
    assign w_idle       = rst_in && (r_state == S_IDLE);
    assign w_rd_ok      = rd_req_valid_in && (r_outst < OW'(MAX_RD_OUTSTANDING));
    assign w_burst_full = (r_burst >= BW'(MAX_WR_BURST));
    assign w_wr_grant   = w_idle && wr_valid_in && !(w_rd_ok && w_burst_full);
    assign w_rd_grant   = w_idle && w_rd_ok && !w_wr_grant;

    assign w_wr_off = wr_tuser_in    ? '0 : r_wr_ptr;
    assign w_rd_off = rd_newframe_in ? '0 : r_rd_ptr;
    assign w_wr_nxt = (w_wr_off == PW'(FRAME_WORDS - 1)) ? '0 : w_wr_off + PW'(1);
    assign w_rd_nxt = (w_rd_off == PW'(FRAME_WORDS - 1)) ? '0 : w_rd_off + PW'(1);

    assign w_cmd_acc   = r_app_en && app_rdy_in;
    assign w_rd_acc    = w_cmd_acc && (r_state == S_READ);
    // A return with nothing outstanding is spurious and is dropped.
    assign w_ret       = app_rd_data_valid_in && (r_outst != '0);
    assign w_en_hold   = r_app_en   && !app_rdy_in;
    assign w_wren_hold = r_wdf_wren && !app_wdf_rdy_in;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_burst    <= '0;
            r_outst    <= '0;
            r_app_en   <= 1'b0;
            r_app_cmd  <= CMD_WR;
            r_app_addr <= '0;
            r_wdf_data <= '0;
            r_wdf_wren <= 1'b0;
            r_rd_vld   <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_vld  <= w_ret;
            r_rd_data <= app_rd_data_in;

            case ({w_rd_acc, w_ret})
                2'b10:   r_outst <= r_outst + OW'(1);
                2'b01:   r_outst <= r_outst - OW'(1);
                default: r_outst <= r_outst;
            endcase

            // Burst counter saturates: with reads blocked by the outstanding
            // limit, writes keep flowing past MAX_WR_BURST.
            if (w_rd_grant || !wr_valid_in)
                r_burst <= '0;
            else if (w_wr_grant && !w_burst_full)
                r_burst <= r_burst + BW'(1);

            case (r_state)
                S_IDLE: begin
                    if (w_wr_grant) begin
                        r_state    <= S_WRITE;
                        r_app_en   <= 1'b1;
                        r_wdf_wren <= 1'b1;
                        r_app_cmd  <= CMD_WR;
                        r_app_addr <= f_addr(w_wr_off);
                        r_wdf_data <= wr_data_in;
                        r_wr_ptr   <= w_wr_nxt;
                    end else if (w_rd_grant) begin
                        r_state    <= S_READ;
                        r_app_en   <= 1'b1;
                        r_app_cmd  <= CMD_RD;
                        r_app_addr <= f_addr(w_rd_off);
                        r_rd_ptr   <= w_rd_nxt;
                    end
                end
                S_WRITE: begin
                    // Command and data channels complete independently.
                    r_app_en   <= w_en_hold;
                    r_wdf_wren <= w_wren_hold;
                    if (!w_en_hold && !w_wren_hold)
                        r_state <= S_IDLE;
                end
                S_READ: begin
                    if (app_rdy_in) begin
                        r_app_en <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wr_ready_out      = w_wr_grant;
    assign rd_req_ready_out  = w_rd_grant;
    assign rd_data_valid_out = r_rd_vld;
    assign rd_data_out       = r_rd_data;
    assign app_addr_out      = r_app_addr;
    assign app_cmd_out       = r_app_cmd;
    assign app_en_out        = r_app_en;
    assign app_wdf_data_out  = r_wdf_data;
    assign app_wdf_wren_out  = r_wdf_wren;
    assign app_wdf_end_out   = r_wdf_wren;

`ifdef ARB_STATS_EN
    logic [31:0] r_wr_cnt;
    logic [31:0] r_rd_cnt;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else if (w_cmd_acc) begin
            if (r_app_cmd == CMD_RD)
                r_rd_cnt <= r_rd_cnt + 32'd1;
            else
                r_wr_cnt <= r_wr_cnt + 32'd1;
        end
    end

    assign wr_count_out = r_wr_cnt;
    assign rd_count_out = r_rd_cnt;
`else
    assign wr_count_out = 32'd0;
    assign rd_count_out = 32'd0;
`endif

endmodule
